// File: rtl/stb_trace_pattern_gen.sv
// Synthetic counter/LFSR trace source feeding the StreamTraceBuffer FPGA write port.
// Optional LFSR pattern mode is built only when STB_TRACE_GEN_LFSR_EN is defined.
module stb_trace_pattern_gen #(
  parameter int TRACE_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   START_I,
  input  logic                   STOP_I,
  input  logic                   MODE_I,
  input  logic [TRACE_WIDTH-1:0] SEED_I,
  input  logic [CNT_WIDTH-1:0]   LENGTH_I,
  input  logic [CNT_WIDTH-1:0]   TRIG_IDX_I,
  input  logic                   TRACE_READY_I,
  output logic                   TRACE_VALID_O,
  output logic [TRACE_WIDTH-1:0] TRACE_O,
  output logic                   TRIG_O,
  output logic                   BUSY_O,
  output logic                   DONE_O,
  output logic [CNT_WIDTH-1:0]   SAMPLE_CNT_O
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam logic [TRACE_WIDTH-1:0] PAT_ONE = {{(TRACE_WIDTH-1){1'b0}}, 1'b1};

`ifdef STB_TRACE_GEN_LFSR_EN
  // Galois right-shift masks: bit (t-1) set for every maximal-length tap t.
  function automatic logic [63:0] lfsrMask64(input int w);
    logic [63:0] m;
    case (w)
      2:       m = 64'h3;
      3:       m = 64'h6;
      4:       m = 64'hC;
      5:       m = 64'h14;
      6:       m = 64'h30;
      7:       m = 64'h60;
      8:       m = 64'hB8;
      9:       m = 64'h110;
      10:      m = 64'h240;
      11:      m = 64'h500;
      12:      m = 64'h829;
      13:      m = 64'h100D;
      14:      m = 64'h2015;
      15:      m = 64'h6000;
      16:      m = 64'hD008;
      17:      m = 64'h12000;
      18:      m = 64'h20400;
      19:      m = 64'h40023;
      20:      m = 64'h90000;
      21:      m = 64'h140000;
      22:      m = 64'h300000;
      23:      m = 64'h420000;
      24:      m = 64'hE10000;
      25:      m = 64'h1200000;
      26:      m = 64'h2000023;
      27:      m = 64'h4000013;
      28:      m = 64'h9000000;
      29:      m = 64'h14000000;
      30:      m = 64'h20000029;
      31:      m = 64'h48000000;
      32:      m = 64'h80200003;
      64:      m = 64'hD800000000000000;
      default: m = (64'd1 << (w - 1)) | 64'd1;
    endcase
    return m;
  endfunction

  localparam logic [63:0]            MASK64    = lfsrMask64(TRACE_WIDTH);
  localparam logic [TRACE_WIDTH-1:0] LFSR_MASK = MASK64[TRACE_WIDTH-1:0];

  logic mode_q, mode_d;
`else
  logic unusedMode;
  assign unusedMode = MODE_I;
`endif

  stateT                  state_q, state_d;
  logic [CNT_WIDTH-1:0]   length_q, length_d;
  logic [CNT_WIDTH-1:0]   trigIdx_q, trigIdx_d;
  logic [CNT_WIDTH-1:0]   sampleCnt_q, sampleCnt_d;
  logic [TRACE_WIDTH-1:0] pattern_q, pattern_d;
  logic                   valid_q, valid_d;
  logic                   trig_q, trig_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   xfer;
  logic                   lastXfer;
  logic [CNT_WIDTH-1:0]   cntInc;
  logic [TRACE_WIDTH-1:0] patNext;
  logic [TRACE_WIDTH-1:0] seedLoad;

  // Next-state decode; every output is taken from a register so READY never reaches an output combinationally.
  always_comb begin
    state_d     = state_q;
    length_d    = length_q;
    trigIdx_d   = trigIdx_q;
    sampleCnt_d = sampleCnt_q;
    pattern_d   = pattern_q;
    valid_d     = valid_q;
    trig_d      = trig_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef STB_TRACE_GEN_LFSR_EN
    mode_d      = mode_q;
`endif

    xfer     = valid_q & TRACE_READY_I;
    cntInc   = sampleCnt_q + 1'b1;
    lastXfer = xfer && (length_q != '0) && (sampleCnt_q == length_q - 1'b1);
    seedLoad = SEED_I;
    patNext  = pattern_q + 1'b1;
`ifdef STB_TRACE_GEN_LFSR_EN
    if (mode_q) begin
      patNext = pattern_q[0] ? ((pattern_q >> 1) ^ LFSR_MASK) : (pattern_q >> 1);
    end
    if (MODE_I && (SEED_I == '0)) begin
      seedLoad = PAT_ONE;
    end
`endif

    case (state_q)
      IDLE: begin
        if (START_I) begin
          state_d     = RUN;
          length_d    = LENGTH_I;
          trigIdx_d   = TRIG_IDX_I;
          sampleCnt_d = '0;
          pattern_d   = seedLoad;
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          trig_d      = (TRIG_IDX_I == '0);
`ifdef STB_TRACE_GEN_LFSR_EN
          mode_d      = MODE_I;
`endif
        end
      end
      RUN: begin
        if (xfer) begin
          sampleCnt_d = cntInc;
          pattern_d   = patNext;
        end
        if (STOP_I || lastXfer) begin
          state_d = DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          trig_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          trig_d = (sampleCnt_d == trigIdx_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        trig_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      length_q    <= '0;
      trigIdx_q   <= '0;
      sampleCnt_q <= '0;
      pattern_q   <= '0;
      valid_q     <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef STB_TRACE_GEN_LFSR_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      trigIdx_q   <= trigIdx_d;
      sampleCnt_q <= sampleCnt_d;
      pattern_q   <= pattern_d;
      valid_q     <= valid_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef STB_TRACE_GEN_LFSR_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign TRACE_VALID_O = valid_q;
  assign TRACE_O       = pattern_q;
  assign TRIG_O        = trig_q;
  assign BUSY_O        = busy_q;
  assign DONE_O        = done_q;
  assign SAMPLE_CNT_O  = sampleCnt_q;

endmodule
